// File: rtl/rot_arbiter.sv
`timescale 1ns/1ps
// rot_arbiter
//   Round-robin front end for one shared 32-bit left barrel rotator. NREQ
//   requesters each offer a word, a 5-bit rotate amount and a direction over
//   valid/ready. At most one request is accepted per cycle. The rotated word
//   and the winner's index are registered into a single-entry response slot,
//   which drains through a valid/ready response port.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid                     [NREQ]
//   req_ready  per-requester accept, one-hot or zero           [NREQ]
//   req_data   operands, requester i at [32*i+31:32*i]         [32*NREQ]
//   req_amnt   rotate amounts, requester i at [5*i+4:5*i]      [5*NREQ]
//   req_dir    0 = rotate left, 1 = rotate right               [NREQ]
//   rsp_valid  response slot holds a result
//   rsp_ready  consumer accepts the result
//   rsp_data   rotated word
//   rsp_id     index of the requester that produced rsp_data   [IDW]
module rot_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [5*NREQ-1:0]    req_amnt,
  input  logic [NREQ-1:0]      req_dir,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // The datapath only rotates left; a right rotate by n is a left rotate by
  // the 5-bit two's complement of n (amount 0 stays 0).
  function automatic logic [4:0] eff_amount(input logic [4:0] amnt,
                                            input logic       dir);
    return dir ? 5'(~amnt + 5'd1) : amnt;
  endfunction

  // Left rotate: shift the doubled word and keep the upper half.
  function automatic logic [31:0] rotl32(input logic [31:0] d,
                                         input logic [4:0]  s);
    logic [63:0] t;
    t = {d, d} << s;
    return t[63:32];
  endfunction

  logic [0:0]      state_q, state_d;
  logic [31:0]     data_q,  data_d;
  logic [IDW-1:0]  id_q,    id_d;
  logic [IDW-1:0]  ptr_q,   ptr_d;
  // Low for the first cycle out of reset so no request is accepted then.
  logic            warm_q;

  logic            slot_free;
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  ptr_nxt;
  logic            grant;
  logic [31:0]     sel_data;
  logic [4:0]      sel_amnt;
  logic            sel_dir;
  logic [31:0]     rot_res;
  int              idx;

  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

  // Search from ptr upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign grant   = win_found && slot_free && !rst && warm_q;
  assign ptr_nxt = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready = NREQ'(1) << win_idx;
  end

  // Operand mux for the winner.
  always_comb begin
    sel_data = '0;
    sel_amnt = '0;
    sel_dir  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_idx) begin
        sel_data = req_data[32*i +: 32];
        sel_amnt = req_amnt[5*i +: 5];
        sel_dir  = req_dir[i];
      end
    end
  end

  assign rot_res = rotl32(sel_data, eff_amount(sel_amnt, sel_dir));

  // A consume and an accept in the same cycle simply reload the slot, so
  // rsp_valid stays high with no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = ST_FULL;
      data_d  = rot_res;
      id_d    = win_idx;
      ptr_d   = ptr_nxt;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      warm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      warm_q  <= 1'b1;
    end
  end

  // Outputs come straight from registers: no path from rsp_ready.
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_rot_arbiter.sv
`timescale 1ns/1ps
module tb_rot_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_data;
  logic [5*NREQ-1:0]   req_amnt;
  logic [NREQ-1:0]     req_dir;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit              m_full;
  logic [31:0]     m_data;
  int              m_id;
  int              m_ptr;
  bit              m_warm;
  logic [NREQ-1:0] m_last_er;

  rot_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amnt(req_amnt), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Rotate one bit position at a time in the requested direction.
  function automatic logic [31:0] ref_rot(input logic [31:0] d, input int n, input bit right);
    logic [31:0] x;
    x = d;
    for (int s = 0; s < n; s++)
      x = right ? {x[0], x[31:1]} : {x[30:0], x[31]};
    return x;
  endfunction

  function automatic int ref_winner();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_warm = 0; m_last_er = '0;
  endtask

  // Check outputs against the model, take one clock edge, advance the model.
  task automatic cycle();
    int w;
    bit g;
    logic [NREQ-1:0] er;
    #1;
    w  = ref_winner();
    er = '0;
    g  = 0;
    if (!rst && m_warm && (!m_full || rsp_ready) && w >= 0) begin
      er[w] = 1'b1;
      g = 1;
    end
    m_last_er = er;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("rsp_data",  rsp_data, m_data);
    chk("rsp_id",    32'(rsp_id), 32'(m_id));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g) begin
        m_full = 1;
        m_data = ref_rot(req_data[32*w +: 32], int'(req_amnt[5*w +: 5]), req_dir[w]);
        m_id   = w;
        m_ptr  = (w + 1) % NREQ;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
      m_warm = 1;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic dr);
    req_data[32*i +: 32] = d;
    req_amnt[5*i +: 5]   = a;
    req_dir[i]           = dr;
  endtask

  task automatic one_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic dr);
    set_req(i, d, a, dr);
    req_valid = '0;
    req_valid[i] = 1'b1;
    cycle();
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_amnt = '0; req_dir = '0; rsp_ready = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cycle();
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_data",  rsp_data, 32'h0);
    chk("reset_id",    32'(rsp_id), 32'd0);

    // Left rotate, single requester; first cycle out of reset refuses.
    rst = 1'b0;
    set_req(0, 32'h80000001, 5'd4, 1'b0);
    req_valid = 4'b0001;
    #1 chk("warm_ready", 32'(req_ready), 32'd0);
    cycle();
    #1 chk("lr_ready", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;
    chk("lr_valid", 32'(rsp_valid), 32'd1);
    chk("lr_data",  rsp_data, 32'h00000018);
    chk("lr_id",    32'(rsp_id), 32'd0);

    // Right rotate and wrap cases, requester 2.
    one_req(2, 32'h00000018, 5'd4, 1'b1);
    chk("rr4_data", rsp_data, 32'h80000001);
    chk("rr4_id",   32'(rsp_id), 32'd2);
    one_req(2, 32'h00000001, 5'd1, 1'b1);
    chk("rr1_data", rsp_data, 32'h80000000);
    one_req(2, 32'h00000001, 5'd31, 1'b0);
    chk("lr31_data", rsp_data, 32'h80000000);
    one_req(2, 32'h12345678, 5'd0, 1'b1);
    chk("rr0_data", rsp_data, 32'h12345678);
    cycle();
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Round-robin fairness from a fresh reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 5'(i), 1'b0);
    req_valid = 4'b1111;
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id",    32'(rsp_id), 32'(k % NREQ));
    end

    // Backpressure: accept requester 0, then stall with 1 and 3 pending.
    set_req(0, 32'h0000000F, 5'd8, 1'b0);
    req_valid = 4'b0001;
    cycle();
    chk("bp_data", rsp_data, 32'h00000F00);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      cycle();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data",  rsp_data, 32'h00000F00);
      chk("bp_hold_id",    32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
    cycle();
    chk("bp_nobubble", 32'(rsp_valid), 32'd1);
    chk("bp_id",       32'(rsp_id), 32'd1);

    // Reset while FULL with requester 3 pending.
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data",  rsp_data, 32'h0);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    cycle();
    chk("rst_warm_valid", 32'(rsp_valid), 32'd0);
    #1 chk("rst_prio_ready", 32'(req_ready), 32'b0001);
    cycle();
    chk("rst_prio_id", 32'(rsp_id), 32'd0);

    // Randomized traffic; stalled requesters usually hold their request.
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !m_last_er[i] && $urandom_range(0, 7) != 0)) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
